// File: rtl/knock_pkg.sv
// Shared definitions for the 4-input wormhole output arbiter.
package knock_pkg;

  localparam int unsigned NUM_REQ = 4;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  // Index of the set bit of a one-hot vector; 0 when the vector is empty.
  function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Round-robin picker: first set request at or after ptr, scanning upward modulo 4.
module rr_pick4
  import knock_pkg::*;
(
  input  logic [NUM_REQ-1:0] request,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  logic [1:0] idx;

  // Walk the four candidates starting at ptr and keep the first hit.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!valid && request[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wormhole_arb4.sv
// Four-input wormhole output arbiter with round-robin packet-level locking.
// Optional per-requester packet-grant counters when ARB_GRANT_CNT_EN is defined.
module wormhole_arb4
  import knock_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              request,
  input  logic [NUM_REQ-1:0]              tail_i,
  input  logic                            buffer_full_i,
  output logic [NUM_REQ-1:0]              grant,
`ifdef ARB_GRANT_CNT_EN
  output logic [NUM_REQ-1:0][CNT_W-1:0]   grant_cnt_o,
`endif
  output logic                            grant_v_o,
  output logic                            busy_o
);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] pick;
  logic               pick_valid;
  logic               take;
  logic [1:0]         owner;

  rr_pick4 u_pick (
    .request (request),
    .ptr     (rr_ptr_q),
    .pick    (pick),
    .valid   (pick_valid)
  );

  assign owner     = onehot_idx(grant_q);
  assign busy_o    = (state_q == LOCKED);
  assign grant     = grant_q;
  assign grant_v_o = busy_o & (|(request & grant_q)) & ~buffer_full_i;
  // A new packet wins the output on this edge.
  assign take      = (state_q == IDLE) & pick_valid & ~buffer_full_i;

  // Next-state: lock on a pick, release one cycle after the owner's tail transfers.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (take) begin
          state_d = LOCKED;
          grant_d = pick;
        end
      end
      LOCKED: begin
        if (grant_v_o && (|(tail_i & grant_q))) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = owner + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef ARB_GRANT_CNT_EN
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q;
  logic [1:0]                    pick_idx;

  assign pick_idx    = onehot_idx(pick);
  assign grant_cnt_o = cnt_q;

  // Saturating count of packets granted to each requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (take && (cnt_q[pick_idx] != {CNT_W{1'b1}})) begin
      cnt_q[pick_idx] <= cnt_q[pick_idx] + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W == 0);
`endif

endmodule
